// File: rtl/calc_display_buffer.sv
// Eight-digit symbol buffer feeding registered active-low seven-segment vectors,
// with a busy decimal point and a blinking "Erro" message while the core reports an error.
module calc_display_buffer #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  input  logic [1:0] status,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic [7:0] e,
  output logic [7:0] f,
  output logic [7:0] g,
  output logic [7:0] dp,
  output logic [1:0] dbg_state_o
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    BUSY    = 2'd1,
    ERR_ON  = 2'd2,
    ERR_OFF = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    mem_q [8];
  logic [7:0]    a_q, b_q, c_q, d_q, e_q, f_q, g_q, dp_q;
  logic [7:0]    a_d, b_d, c_d, d_d, e_d, f_d, g_d, dp_d;

  // Returns {a,b,c,d,e,f,g}, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] sym);
    case (sym)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      4'd10:   glyph = 7'b1111110;
      4'd11:   glyph = 7'b0110000;
      4'd12:   glyph = 7'b1111010;
      4'd13:   glyph = 7'b1100010;
      4'd14:   glyph = 7'b0011000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // "Erro" sits on digits 3..0; the upper half stays blank.
  function automatic logic [3:0] err_sym(input int unsigned idx);
    case (idx)
      3:       err_sym = 4'd11;
      2, 1:    err_sym = 4'd12;
      0:       err_sym = 4'd13;
      default: err_sym = 4'd15;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (status[1]) begin
      if (state_q == SHOW || state_q == BUSY) begin
        state_d = ERR_ON;
      end else if (cnt_q == CNT_LAST) begin
        state_d = (state_q == ERR_ON) ? ERR_OFF : ERR_ON;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = status[0] ? BUSY : SHOW;
    end
  end

  always_comb begin
    a_d  = '1;
    b_d  = '1;
    c_d  = '1;
    d_d  = '1;
    e_d  = '1;
    f_d  = '1;
    g_d  = '1;
    dp_d = '1;
    if (state_q != ERR_OFF) begin
      for (int unsigned i = 0; i < 8; i++) begin
        {a_d[i], b_d[i], c_d[i], d_d[i], e_d[i], f_d[i], g_d[i]} =
          glyph((state_q == ERR_ON) ? err_sym(i) : mem_q[i]);
      end
    end
    if (state_q == BUSY) dp_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      for (int i = 0; i < 8; i++) mem_q[i] <= 4'hF;
      a_q  <= '1;
      b_q  <= '1;
      c_q  <= '1;
      d_q  <= '1;
      e_q  <= '1;
      f_q  <= '1;
      g_q  <= '1;
      dp_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pos[3]) mem_q[pos[2:0]] <= data;
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      d_q  <= d_d;
      e_q  <= e_d;
      f_q  <= f_d;
      g_q  <= g_d;
      dp_q <= dp_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign e           = e_q;
  assign f           = f_q;
  assign g           = g_q;
  assign dp          = dp_q;
  assign dbg_state_o = state_q;

endmodule
